// File: rtl/ppu_linebuf.sv
// Ping-pong line buffer: one bank fills from the source while the other drains
// through a per-line pixel transform, with end-of-line/end-of-frame markers.
module ppu_linebuf #(
   parameter int DATA_W   = 8,
   parameter int LINE_LEN = 32,
   parameter int IDX_W    = 5,
   parameter int LINES    = 32,
   parameter int V_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sync,
   input  logic [2:0]        mode,
   input  logic [DATA_W-1:0] data_i,
   input  logic              stb_i,
   output logic              ack_i,
   output logic [DATA_W-1:0] data_o,
   output logic              stb_o,
   input  logic              ack_o,
   output logic              eol_o,
   output logic              eof_o
);

   localparam logic [IDX_W-1:0] H_LAST = IDX_W'(LINE_LEN - 1);
   localparam logic [V_W-1:0]   V_LAST = V_W'(LINES - 1);

   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [0:1][0:LINE_LEN-1];
   logic [1:0]        full;
   logic              wr_bank, rd_bank;
   logic [IDX_W-1:0]  wr_idx, h, h_sel, src, v_idx;
   logic [V_W-1:0]    v;
   logic [2:0]        mode_q, m_sel;
   logic [DATA_W-1:0] p, pix;
   logic              in_xfer, load, adv, done;
   logic              eol_nxt, eof_nxt;

   assign ack_i   = ~full[wr_bank];
   assign stb_o   = (state == SEND);
   assign in_xfer = stb_i & ack_i & ~sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // load: line start in IDLE; adv: next pixel within line; done: last pixel taken
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      adv       = 1'b0;
      done      = 1'b0;
      if (sync) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (full[rd_bank]) begin
               load      = 1'b1;
               state_nxt = SEND;
            end
            SEND: if (ack_o) begin
               if (h == H_LAST) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  adv = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Pixel about to be presented: h=0 with the live mode on load, else h+1 with mode_q.
   always_comb begin
      m_sel = load ? mode : mode_q;
      h_sel = load ? '0 : h + 1'b1;
      v_idx = IDX_W'(v);
      case (m_sel)
         3'd2:    src = H_LAST - h_sel;
         3'd4:    src = h_sel >> 1;
         3'd5:    src = h_sel + v_idx;
         default: src = h_sel;
      endcase
      p = mem[rd_bank][src];
      case (m_sel)
         3'd1:    pix = ~p;
         3'd3:    pix = {DATA_W{p[DATA_W-1]}};
         default: pix = p;
      endcase
      eol_nxt = (h_sel == H_LAST);
      eof_nxt = eol_nxt & (v == V_LAST);
   end

   always_ff @(posedge clk) begin
      if (in_xfer) mem[wr_bank][wr_idx] <= data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full    <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_idx  <= '0;
         h       <= '0;
         v       <= '0;
         mode_q  <= '0;
         data_o  <= '0;
         eol_o   <= 1'b0;
         eof_o   <= 1'b0;
      end else if (sync) begin
         full    <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_idx  <= '0;
         h       <= '0;
         v       <= '0;
         eol_o   <= 1'b0;
         eof_o   <= 1'b0;
      end else begin
         if (in_xfer) begin
            if (wr_idx == H_LAST) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
               wr_idx        <= '0;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end
         if (load) mode_q <= mode;
         if (load | adv) begin
            h      <= h_sel;
            data_o <= pix;
            eol_o  <= eol_nxt;
            eof_o  <= eof_nxt;
         end
         // Freed bank is never the one being written, so both full updates can land together.
         if (done) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            h             <= '0;
            v             <= (v == V_LAST) ? '0 : v + 1'b1;
            eol_o         <= 1'b0;
            eof_o         <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ppu_linebuf.sv
// Bench for ppu_linebuf: directed and randomized lines checked against a
// line-level reference model holding expected output pixels in a queue.
module tb_ppu_linebuf;

   logic       clk = 1'b0;
   logic       rst, sync, stb_i, ack_o;
   logic [2:0] mode;
   logic [7:0] data_i, data_o;
   logic       ack_i, stb_o, eol_o, eof_o;

   int checks = 0, failures = 0, out_cnt = 0, eof_cnt = 0, v_m = 0;
   bit rnd = 1'b0;
   logic [7:0] ln [32];
   logic [7:0] cur [$];

   typedef struct {
      logic [7:0] d;
      logic       eol;
      logic       eof;
   } exp_t;
   exp_t exp_q [$];

   ppu_linebuf dut (
      .clk(clk), .rst(rst), .sync(sync), .mode(mode),
      .data_i(data_i), .stb_i(stb_i), .ack_i(ack_i),
      .data_o(data_o), .stb_o(stb_o), .ack_o(ack_o),
      .eol_o(eol_o), .eof_o(eof_o)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: a completed line becomes 32 expected output pixels under mode md at line v_m.
   function automatic void push_line(input int md);
      exp_t e;
      int   s;
      logic [7:0] p;
      for (int hh = 0; hh < 32; hh++) begin
         case (md)
            2:       s = 31 - hh;
            4:       s = hh / 2;
            5:       s = (hh + v_m) % 32;
            default: s = hh;
         endcase
         p = cur[s];
         case (md)
            1:       e.d = ~p;
            3:       e.d = (p >= 8'd128) ? 8'hFF : 8'h00;
            default: e.d = p;
         endcase
         e.eol = (hh == 31);
         e.eof = (hh == 31) && (v_m == 31);
         exp_q.push_back(e);
      end
      v_m = (v_m + 1) % 32;
      cur.delete();
   endfunction

   task automatic step();
      logic in_x, out_x, oe, of, sy;
      logic [7:0] od, id;
      exp_t e;
      sy    = sync;
      in_x  = stb_i & ack_i & ~sync;
      out_x = stb_o & ack_o & ~sync;
      od = data_o; oe = eol_o; of = eof_o; id = data_i;
      @(posedge clk);
      #1;
      if (sy) begin
         exp_q.delete();
         cur.delete();
         v_m = 0;
      end else begin
         if (out_x) begin
            out_cnt++;
            if (of) eof_cnt++;
            chk("out_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("pix_data", od, e.d);
               chk("pix_eol", oe, e.eol);
               chk("pix_eof", of, e.eof);
            end
         end
         if (in_x) begin
            cur.push_back(id);
            if (cur.size() == 32) push_line(int'(mode));
         end
      end
      if (rnd) ack_o = ($urandom_range(0, 3) != 0);
   endtask

   task automatic feed_n(input int n);
      int w;
      for (int i = 0; i < n; i++) begin
         if (rnd && $urandom_range(0, 2) == 0) begin
            stb_i = 1'b0;
            step();
         end
         data_i = ln[i];
         stb_i  = 1'b1;
         w = 0;
         while (!ack_i && w < 300) begin
            step();
            w++;
         end
         chk("feed_ack", ack_i, 1);
         step();
      end
      stb_i = 1'b0;
   endtask

   task automatic drain(output int n);
      n = 0;
      while (exp_q.size() != 0 && n < 600) begin
         step();
         n++;
      end
      chk("drain_done", exp_q.size(), 0);
   endtask

   initial begin
      int n, base, w;
      int mds [3] = '{1, 2, 4};
      logic [7:0] held;

      rst = 1'b1; sync = 1'b0; stb_i = 1'b0; ack_o = 1'b0; mode = 3'd0; data_i = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack_i", ack_i, 1);
      chk("rst_stb_o", stb_o, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_eol_o", eol_o, 0);
      chk("rst_eof_o", eof_o, 0);
      rst = 1'b0;
      step();
      chk("idle_ack_i", ack_i, 1);
      chk("idle_stb_o", stb_o, 0);

      // Pass-through, latency and throughput
      ack_o = 1'b1;
      for (int i = 0; i < 32; i++) ln[i] = 8'(i);
      feed_n(32);
      chk("lat_pre", stb_o, 0);
      step();
      chk("lat_post", stb_o, 1);
      drain(n);
      chk("thru_cycles", n, 32);
      chk("stb_after_line", stb_o, 0);

      foreach (mds[k]) begin
         mode = 3'(mds[k]);
         feed_n(32);
         drain(n);
      end

      // Diagonal scroll over a full frame
      sync = 1'b1;
      step();
      sync = 1'b0;
      mode = 3'd5;
      base = eof_cnt;
      for (int l = 0; l < 32; l++) feed_n(32);
      drain(n);
      chk("eof_count", eof_cnt - base, 1);
      feed_n(32);
      drain(n);

      // Backpressure mid-line
      mode = 3'd0;
      for (int i = 0; i < 32; i++) ln[i] = 8'($urandom);
      feed_n(32);
      base = out_cnt;
      w = 0;
      while (out_cnt - base < 10 && w < 100) begin
         step();
         w++;
      end
      chk("bp_reached", out_cnt - base, 10);
      ack_o = 1'b0;
      held = data_o;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_data_hold", data_o, held);
         chk("bp_stb_hold", stb_o, 1);
      end
      ack_o = 1'b1;
      drain(n);

      // Both banks full, then recovery after one line drains
      ack_o = 1'b0;
      feed_n(32);
      for (int i = 0; i < 32; i++) ln[i] = 8'($urandom);
      feed_n(32);
      chk("full_ack_low", ack_i, 0);
      stb_i = 1'b1;
      data_i = 8'h5A;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("full_ack_stays_low", ack_i, 0);
      end
      stb_i = 1'b0;
      ack_o = 1'b1;
      base = out_cnt;
      w = 0;
      while (!ack_i && w < 100) begin
         step();
         w++;
      end
      chk("freed_after_line", out_cnt - base, 32);
      chk("gap_idle", stb_o, 0);
      step();
      chk("gap_resume", stb_o, 1);
      drain(n);

      // sync mid-input and mid-output
      for (int i = 0; i < 32; i++) ln[i] = 8'($urandom);
      feed_n(32);
      feed_n(10);
      chk("sync_pre_stb", stb_o, 1);
      sync = 1'b1;
      stb_i = 1'b1;
      data_i = 8'hAA;
      step();
      sync = 1'b0;
      stb_i = 1'b0;
      chk("sync_stb_o", stb_o, 0);
      chk("sync_ack_i", ack_i, 1);
      chk("sync_eol_o", eol_o, 0);
      chk("sync_eof_o", eof_o, 0);
      mode = 3'd5;
      for (int i = 0; i < 32; i++) ln[i] = 8'($urandom);
      feed_n(32);
      step();
      chk("sync_first_pix", data_o, ln[0]);
      drain(n);

      // Randomized lines, modes, gaps and backpressure
      rnd = 1'b1;
      for (int l = 0; l < 12; l++) begin
         mode = 3'($urandom_range(0, 7));
         for (int i = 0; i < 32; i++) ln[i] = 8'($urandom);
         feed_n(32);
         drain(n);
      end
      rnd = 1'b0;
      ack_o = 1'b1;
      step();
      chk("final_idle_stb", stb_o, 0);
      chk("final_ack_i", ack_i, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ppu_linebuf.md
# ppu_linebuf

Parametrised pixel processing unit with ping-pong line buffering. It sits between the pixel source and the VGA output stage. Pixels arrive over a strobe/ack handshake and fill one line bank while the other bank drains through a per-line mode transform. Output is one pixel per cycle under backpressure, with end-of-line and end-of-frame markers and frame restart on `sync`.

## Interface
- `DATA_W`, 8: pixel width in bits.
- `LINE_LEN`, 32: pixels per line; power of two, at least 4.
- `IDX_W`, 5: log2(LINE_LEN).
- `LINES`, 32: lines per frame.
- `V_W`, 5: width of the line counter; 2^V_W ≥ LINES.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sync`  in  1  synchronous frame restart, active-high, level-sampled.
- `mode`  in  3  transform select; latched per line.
- `data_i`  in  DATA_W  input pixel.
- `stb_i`  in  1  input pixel valid.
- `ack_i`  out  1  input ready; a transfer occurs on an edge with `stb_i & ack_i`.
- `data_o`  out  DATA_W  transformed pixel.
- `stb_o`  out  1  output valid; a transfer occurs on an edge with `stb_o & ack_o`.
- `ack_o`  in  1  sink ready.
- `eol_o`  out  1  asserted with the last pixel of each line.
- `eof_o`  out  1  asserted with the last pixel of the last line of the frame.

## Operation
- Storage is 2 banks × LINE_LEN × DATA_W. State registers: `full[1:0]`, `wr_bank`, `wr_idx`, `rd_bank`, `h` (IDX_W bits), `v` (V_W bits), `mode_q`.
- `ack_i = ~full[wr_bank]`. It derives from registers only and has no combinational path from `stb_i`.
- On an input transfer:
  - Write `data_i` to `[wr_bank][wr_idx]`.
  - If `wr_idx == LINE_LEN-1`: set `full[wr_bank]`, toggle `wr_bank`, set `wr_idx = 0`.
  - Otherwise increment `wr_idx`.
- Output FSM has two states:
  - IDLE: if `full[rd_bank]`, latch `mode_q <= mode`, load the pixel for `h = 0`, set `stb_o = 1`, go to SEND.
  - SEND: hold `data_o`, `eol_o` and `eof_o` stable while `ack_o = 0`.
    - On a transfer with `h < LINE_LEN-1`: increment `h` and load the next pixel in the same edge, so `stb_o` stays high.
    - On a transfer with `h == LINE_LEN-1`: clear `full[rd_bank]`, toggle `rd_bank`, set `h = 0`, set `v = (v == LINES-1) ? 0 : v+1`, drop `stb_o`, go to IDLE.
- Source index `s` and pixel function by `mode_q`, with `p = buf[rd_bank][s]`:
  - 0: `s = h`, pass-through.
  - 1: `s = h`, output `~p`.
  - 2: `s = LINE_LEN-1-h`, mirror.
  - 3: `s = h`, output all-ones if `p[DATA_W-1]`, else 0 (threshold).
  - 4: `s = h >> 1`, 2× horizontal stretch of the first half-line.
  - 5: `s = (h + v) mod LINE_LEN`, diagonal scroll; the IDX_W-bit add wraps naturally.
  - 6, 7: same as 0.
- `eol_o = (h == LINE_LEN-1)`. `eof_o = eol_o & (v == LINES-1)`. Both are registered alongside `data_o`.
- `sync`:
  - Priority over every transfer in the same cycle; both transfers that cycle are discarded.
  - Next edge: `full = 0`, `wr_bank = rd_bank = 0`, `wr_idx = h = v = 0`, `stb_o = eol_o = eof_o = 0`, FSM to IDLE.
  - Bank contents are not cleared.
- A `mode` change mid-line has no effect until the next line start.

## Timing
- Reset values: `ack_i = 1`, `stb_o = 0`, `data_o = 0`, `eol_o = 0`, `eof_o = 0`; all counters, bank pointers and `full` flags 0; FSM IDLE. Reset mid-line discards all buffered data.
- Latency: if the last pixel of a line is accepted at edge N, `stb_o` rises after edge N+1 and the first pixel is valid then.
- Throughput: with `ack_o` held high, one pixel per cycle within a line, plus 1 idle cycle between lines.
- Input sustains 1 pixel per cycle until both banks are full.
- Both banks full: `ack_i` goes low. A bank freed at edge M raises `ack_i` after edge M.
- A bank freed and the other bank's last write on the same edge is legal and both take effect.
- `ack_o` asserted while `stb_o = 0` is ignored.

## Test plan
- Reset, then idle: `ack_i = 1`, `stb_o = 0`, `data_o = 0`, `eol_o = 0`, `eof_o = 0`.
- Mode 0, feed 0..31 back-to-back with `ack_o = 1`:
  - `stb_o` rises 1 cycle after pixel 31 is accepted.
  - Output 0..31 on consecutive cycles; `eol_o` only with 31.
- Same line in modes 1, 2, 4:
  - Mode 1: `0xFF, 0xFE, …`
  - Mode 2: `31, 30, …, 0`
  - Mode 4: `0, 0, 1, 1, …, 15, 15`
- Mode 5, 32 lines of 0..31:
  - Line k starts at pixel k.
  - `eof_o` with the last pixel of line 31.
  - `v` wraps to 0 afterwards.
- Backpressure:
  - Hold `ack_o = 0` for 5 cycles mid-line: `data_o` stable, `stb_o = 1`.
  - Feed 64 pixels with no drain: `ack_i` drops after 64 accepts and recovers after one line drains.
- `sync` asserted mid-input and mid-output: next cycle `stb_o = 0`, `ack_i = 1`; the next line fed outputs from pixel 0.
